data_mem_ctrl: RTL and testbench
================================

Name: data_mem_ctrl

Overview:
- Parametrised data/instruction memory for the RV32 core.
- Successor to the single-port word-only memory block. Adds:
  - byte/halfword/word access with sign or zero extension
  - byte-lane write masking
  - misalignment and out-of-range error flags
  - a valid/ready request port with configurable read latency
  - a multi-cycle post-reset initialisation sweep
- Sits between the MEM stage (or fetch) and backing storage. LATENCY=0 keeps the asynchronous-read timing the current pipeline depends on.

Parameters:
- ADDR_WIDTH, 10, word-address bits; DEPTH = 2**ADDR_WIDTH 32-bit words.
- LATENCY, 0, request-accept to response cycles; legal range 0..4.
- INIT_VALUE, 32'h00000013, value written to every word by the reset sweep (NOP).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  block can accept a request this cycle
- req_addr  in  32  byte address
- req_we  in  1  1 = store, 0 = load
- req_size  in  2  0 = byte, 1 = half, 2 = word; 3 is reserved and raises an error
- req_unsigned  in  1  load zero-extends when 1
- req_wdata  in  32  store data, right-aligned
- resp_valid  out  1  response pulse, one per accepted request
- resp_rdata  out  32  extended load data; 0 for stores and errors
- resp_err  out  1  misaligned, reserved size, or out-of-range
- init_done  out  1  initialisation sweep complete

Behaviour:
- Reset values: req_ready=0, resp_valid=0, resp_rdata=0, resp_err=0, init_done=0. The response pipeline is flushed. FSM enters INIT with sweep counter 0.
- FSM states: INIT and RUN.
  - INIT: writes INIT_VALUE to mem[counter] once per cycle, then increments the counter. After writing DEPTH-1 it moves to RUN on the next edge. The sweep takes DEPTH cycles.
  - RUN: init_done=1; req_ready=1 every cycle (no backpressure). An accept is req_valid & req_ready.
  - Reset asserted in any state, including mid-sweep, restarts INIT from word 0.
- Requests received during INIT are ignored: no write, no response.
- Word index = req_addr[ADDR_WIDTH+1:2]; lane = req_addr[1:0].
- An error is raised when any of these holds:
  - req_size=3
  - size=1 with lane[0]=1
  - size=2 with lane!=0
  - req_addr[31:ADDR_WIDTH+2] != 0
- On an error: no write, resp_rdata=0, resp_err=1. A response is still produced.
- Store byte mask:
  - byte: 1 << lane
  - half: 2'b11 << lane
  - word: 4'hF
- Store data is replicated across lanes (byte ×4, half ×2) and only masked lanes are written. The write commits on the accept edge.
- Load: selects the byte or half at the lane, then sign-extends (req_unsigned=0) or zero-extends.
- Response timing:
  - LATENCY=0: resp_valid/resp_rdata/resp_err are combinational from the accept cycle, with an asynchronous array read.
  - LATENCY=N≥1: the array read is registered at the accept edge, and the response emerges exactly N cycles after accept through an N-deep valid/data/err shift pipeline.
  - Back-to-back accepts give back-to-back responses, in order.
- Hazards:
  - A load accepted the cycle after a store to the same word returns the new data.
  - One request per cycle, so there is no same-cycle read/write conflict.
- Stores return resp_valid with rdata=0 and err reflecting the checks.

Decomposition:
- Package mem_pkg:
  - typedef enum mem_size_e {MEM_B=0, MEM_H=1, MEM_W=2}
  - typedef struct for a pipeline entry {valid, rdata[31:0], err}
  - MAX_LATENCY=4
- Combinational sub-module mem_lane_align (size, lane, unsigned, wdata, raw word → byte mask, replicated wdata, extended rdata, misalign flag). Shared with future fetch and cache paths.

Test Plan:
- Reset, then wait (ADDR_WIDTH=4) → init_done rises 16 cycles after reset release. Load word 0x3C returns 0x00000013.
- Store word 0x8 ← 0xDEADBEEF; store byte 0x9 ← 0x55; load word 0x8 → 0xDEAD55EF. Load byte 0xB signed → 0xFFFFFFDE; unsigned → 0x000000DE.
- Load half 0x3, store word 0x6, size=3 → resp_err=1, rdata=0, memory unchanged. Address 0x0000_1000 with ADDR_WIDTH=4 → resp_err=1.
- LATENCY=2: accept loads on cycles t, t+1, t+2 → resp_valid on t+2, t+3, t+4 with matching data in order.
- Assert reset for 1 cycle at sweep count 7 after a prior store of 0x1234 to 0x0 → sweep restarts at 0, init_done low for the full DEPTH cycles, load 0x0 returns 0x00000013.
- Requests during INIT → no resp_valid, no memory change. Store then load to the same word on consecutive cycles → load returns the stored value.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared types and constants for the data memory controller.
package mem_pkg;

  localparam int MAX_LATENCY = 4;
  localparam int NUM_LANES   = 4;

  typedef enum logic [1:0] {
    MEM_B = 2'd0,
    MEM_H = 2'd1,
    MEM_W = 2'd2
  } mem_size_e;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } mem_state_e;

  // One slot of the response delay line.
  typedef struct packed {
    logic        valid;
    logic [31:0] rdata;
    logic        err;
  } mem_pipe_t;

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering: store mask/replication, load select/extension, alignment check.
module mem_lane_align
  import mem_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  lane,
  input  logic        is_unsigned,
  input  logic [31:0] wdata,
  input  logic [31:0] raw,
  output logic [3:0]  be,
  output logic [31:0] wdata_rep,
  output logic [31:0] rdata_ext,
  output logic        misalign
);

  logic [31:0] shifted;
  logic [7:0]  sel_b;
  logic [15:0] sel_h;

  // Bring the addressed lane down to bit 0 before extension.
  always_comb begin
    shifted = raw >> {lane, 3'b000};
    sel_b   = shifted[7:0];
    sel_h   = shifted[15:0];
  end

  // Per-size mask, replication and extension; size 3 yields an empty mask.
  always_comb begin
    be        = 4'h0;
    wdata_rep = wdata;
    rdata_ext = raw;
    misalign  = 1'b0;
    case (size)
      MEM_B: begin
        be        = 4'b0001 << lane;
        wdata_rep = {4{wdata[7:0]}};
        rdata_ext = is_unsigned ? {24'h0, sel_b} : {{24{sel_b[7]}}, sel_b};
      end
      MEM_H: begin
        misalign  = lane[0];
        be        = 4'b0011 << lane;
        wdata_rep = {2{wdata[15:0]}};
        rdata_ext = is_unsigned ? {16'h0, sel_h} : {{16{sel_h[15]}}, sel_h};
      end
      MEM_W: begin
        misalign  = (lane != 2'd0);
        be        = 4'hF;
      end
      default: begin
        be        = 4'h0;
      end
    endcase
  end

endmodule

// File: rtl/data_mem_ctrl.sv
// Data/instruction memory with lane access, error flags, init sweep and
// configurable response latency (0 = combinational read path).
module data_mem_ctrl
  import mem_pkg::*;
#(
  parameter int          ADDR_WIDTH = 10,
  parameter int          LATENCY    = 0,
  parameter logic [31:0] INIT_VALUE = 32'h00000013
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        init_done
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] LAST_IDX = '1;

  logic [31:0] mem_q [DEPTH];

  mem_state_e            state_q, state_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;

  logic                  accept;
  logic [ADDR_WIDTH-1:0] word_idx;
  logic [1:0]            lane;
  logic [31:0]           raw;
  logic [3:0]            be;
  logic [31:0]           wdata_rep;
  logic [31:0]           rdata_ext;
  logic                  misalign;
  logic                  range_err;
  logic                  err;

  logic                  wr_en;
  logic [ADDR_WIDTH-1:0] wr_idx;
  logic [31:0]           wr_data;
  logic [3:0]            wr_be;

  mem_pipe_t             now_entry;

  assign word_idx  = req_addr[ADDR_WIDTH+1:2];
  assign lane      = req_addr[1:0];
  assign raw       = mem_q[word_idx];
  assign range_err = (req_addr >> (ADDR_WIDTH + 2)) != 32'd0;
  assign err       = (req_size == 2'd3) | misalign | range_err;
  assign accept    = req_valid & req_ready;

  mem_lane_align u_align (
    .size        (req_size),
    .lane        (lane),
    .is_unsigned (req_unsigned),
    .wdata       (req_wdata),
    .raw         (raw),
    .be          (be),
    .wdata_rep   (wdata_rep),
    .rdata_ext   (rdata_ext),
    .misalign    (misalign)
  );

  // FSM next-state: sweep one word per cycle in INIT, then serve requests.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    req_ready = 1'b0;
    init_done = 1'b0;
    case (state_q)
      ST_INIT: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST_IDX) state_d = ST_RUN;
      end
      ST_RUN: begin
        req_ready = 1'b1;
        init_done = 1'b1;
      end
      default: state_d = ST_INIT;
    endcase
  end

  // FSM state register; reset restarts the sweep from word 0.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_INIT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Single write port shared by the sweep and accepted, error-free stores.
  always_comb begin
    wr_en   = 1'b0;
    wr_idx  = word_idx;
    wr_data = wdata_rep;
    wr_be   = be;
    if (!reset) begin
      if (state_q == ST_INIT) begin
        wr_en   = 1'b1;
        wr_idx  = cnt_q;
        wr_data = INIT_VALUE;
        wr_be   = 4'hF;
      end else begin
        wr_en = accept & req_we & ~err;
      end
    end
  end

  // Byte-masked array write.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int b = 0; b < NUM_LANES; b++) begin
        if (wr_be[b]) mem_q[wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
      end
    end
  end

  // Response for the request accepted this cycle; data only for clean loads.
  always_comb begin
    now_entry.valid = accept;
    now_entry.err   = accept & err;
    now_entry.rdata = (accept & ~err & ~req_we) ? rdata_ext : 32'h0;
  end

  generate
    if (LATENCY == 0) begin : g_comb
      assign resp_valid = now_entry.valid;
      assign resp_rdata = now_entry.rdata;
      assign resp_err   = now_entry.err;
    end else begin : g_pipe
      mem_pipe_t pipe_q [LATENCY];
      mem_pipe_t pipe_d [LATENCY];

      // Delay line: capture at the accept edge, shift one slot per cycle.
      always_comb begin
        pipe_d[0] = now_entry;
        for (int i = 1; i < LATENCY; i++) pipe_d[i] = pipe_q[i-1];
      end

      // Delay line registers, flushed by reset.
      always_ff @(posedge clk) begin
        for (int i = 0; i < LATENCY; i++) begin
          if (reset) pipe_q[i] <= '0;
          else       pipe_q[i] <= pipe_d[i];
        end
      end

      assign resp_valid = pipe_q[LATENCY-1].valid;
      assign resp_rdata = pipe_q[LATENCY-1].rdata;
      assign resp_err   = pipe_q[LATENCY-1].err;
    end
  endgenerate

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Bench: LATENCY=0 and LATENCY=2 instances share stimulus and are checked
// against a byte-addressed memory model.
module tb_data_mem_ctrl;

  localparam int AW    = 4;
  localparam int DEPTH = 1 << AW;
  localparam int NBYTE = DEPTH * 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic [31:0] req_addr;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_wdata;

  logic        rdy0, vld0, err0, done0;
  logic [31:0] rd0;
  logic        rdy2, vld2, err2, done2;
  logic [31:0] rd2;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  data_mem_ctrl #(.ADDR_WIDTH(AW), .LATENCY(0)) dut0 (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(rdy0),
    .req_addr(req_addr), .req_we(req_we), .req_size(req_size),
    .req_unsigned(req_unsigned), .req_wdata(req_wdata),
    .resp_valid(vld0), .resp_rdata(rd0), .resp_err(err0), .init_done(done0)
  );

  data_mem_ctrl #(.ADDR_WIDTH(AW), .LATENCY(2)) dut2 (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(rdy2),
    .req_addr(req_addr), .req_we(req_we), .req_size(req_size),
    .req_unsigned(req_unsigned), .req_wdata(req_wdata),
    .resp_valid(vld2), .resp_rdata(rd2), .resp_err(err2), .init_done(done2)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference model: byte memory plus sweep tracking
  logic [7:0] mb [NBYTE];
  int         since_rst = 0;
  bit         run_m = 0;
  int         cyc = 0;
  bit         hv [8192];
  logic [31:0] hd [8192];
  bit         he [8192];

  function automatic void model_eval(input logic we, input logic [1:0] sz, input logic uns,
                                     input logic [31:0] addr, output bit e, output logic [31:0] rd);
    int n;
    n  = 1 << sz;
    e  = (sz == 2'd3) || ((addr % n) != 0) || (addr >= NBYTE);
    rd = 32'h0;
    if (!e && !we) begin
      for (int b = 0; b < n; b++) rd = rd | (32'(mb[addr + b]) << (8 * b));
      if (!uns && n < 4 && rd[8*n-1]) rd = rd | ~((32'h1 << (8 * n)) - 1);
    end
  endfunction

  // One clock of stimulus: drive, check at negedge, update model at posedge.
  task automatic step(input logic rst, input logic v, input logic we, input logic [1:0] sz,
                      input logic uns, input logic [31:0] addr, input logic [31:0] wd,
                      output logic [31:0] obs0);
    bit          acc, e;
    logic [31:0] erd;
    reset = rst; req_valid = v; req_we = we; req_size = sz;
    req_unsigned = uns; req_addr = addr; req_wdata = wd;
    @(negedge clk);
    acc = v && run_m && !rst;
    model_eval(we, sz, uns, addr, e, erd);
    hv[cyc] = acc; hd[cyc] = erd; he[cyc] = e;
    if (!rst) begin
      chk("init_done0", {31'h0, done0}, {31'h0, run_m});
      chk("init_done2", {31'h0, done2}, {31'h0, run_m});
      chk("ready0", {31'h0, rdy0}, {31'h0, run_m});
      chk("valid0", {31'h0, vld0}, {31'h0, acc});
      if (acc) begin
        chk("rdata0", rd0, erd);
        chk("err0", {31'h0, err0}, {31'h0, e});
      end
      if (cyc >= 2) begin
        chk("valid2", {31'h0, vld2}, {31'h0, hv[cyc-2]});
        if (hv[cyc-2]) begin
          chk("rdata2", rd2, hd[cyc-2]);
          chk("err2", {31'h0, err2}, {31'h0, he[cyc-2]});
        end
      end
    end
    obs0 = rd0;
    @(posedge clk);
    if (acc && we && !e)
      for (int b = 0; b < (1 << sz); b++) mb[addr + b] = 8'(wd >> (8 * b));
    if (rst) begin
      since_rst = 0; run_m = 0;
      hv[cyc] = 0;
      if (cyc >= 1) hv[cyc-1] = 0;
    end else if (!run_m) begin
      since_rst++;
      if (since_rst == DEPTH) begin
        run_m = 1;
        for (int i = 0; i < NBYTE; i++) mb[i] = (i % 4 == 0) ? 8'h13 : 8'h00;
      end
    end
    cyc++;
    #1;
  endtask

  task automatic rnd_step(input logic v);
    logic [31:0] a, o;
    int r;
    r = $urandom_range(0, 19);
    if (r == 0)      a = 32'h0000_1000 | $urandom_range(0, 63);
    else if (r == 1) a = $urandom;
    else             a = $urandom_range(0, NBYTE - 1);
    step(1'b0, v, 1'($urandom), 2'($urandom), 1'($urandom), a, $urandom, o);
  endtask

  initial begin
    logic [31:0] o;
    for (int i = 0; i < NBYTE; i++) mb[i] = 8'h00;
    reset = 1'b1; req_valid = 1'b0; req_addr = '0; req_we = 1'b0;
    req_size = 2'd0; req_unsigned = 1'b0; req_wdata = '0;
    @(posedge clk); #1;
    step(1'b1, 0, 0, 2'd2, 0, 32'h0, 32'h0, o);
    step(1'b1, 0, 0, 2'd2, 0, 32'h0, 32'h0, o);

    // Reset state just after release
    reset = 1'b0;
    @(negedge clk);
    chk("rst_ready", {31'h0, rdy0}, 32'h0);
    chk("rst_valid0", {31'h0, vld0}, 32'h0);
    chk("rst_valid2", {31'h0, vld2}, 32'h0);
    chk("rst_rdata", rd0, 32'h0);
    chk("rst_err", {31'h0, err0 | err2}, 32'h0);
    chk("rst_done", {31'h0, done0 | done2}, 32'h0);
    @(posedge clk); #1;
    since_rst = 1; cyc++;

    // Requests during the sweep must be ignored
    for (int i = 1; i < DEPTH; i++) rnd_step(1'b1);

    // Directed access checks
    step(0, 1, 0, 2'd2, 0, 32'h3C, 0, o);            chk("ld_w3c", o, 32'h00000013);
    step(0, 1, 1, 2'd2, 0, 32'h08, 32'hDEADBEEF, o);
    step(0, 1, 1, 2'd0, 0, 32'h09, 32'h00000055, o);
    step(0, 1, 0, 2'd2, 0, 32'h08, 0, o);            chk("ld_w8", o, 32'hDEAD55EF);
    step(0, 1, 0, 2'd0, 0, 32'h0B, 0, o);            chk("ld_bb_s", o, 32'hFFFFFFDE);
    step(0, 1, 0, 2'd0, 1, 32'h0B, 0, o);            chk("ld_bb_u", o, 32'h000000DE);
    step(0, 1, 0, 2'd1, 0, 32'h03, 0, o);            chk("err_h3", {31'h0, err0}, 32'h1);
    step(0, 1, 1, 2'd2, 0, 32'h06, 32'h11111111, o); chk("err_w6", {31'h0, err0}, 32'h1);
    step(0, 1, 1, 2'd3, 0, 32'h04, 32'h22222222, o); chk("err_sz3", {31'h0, err0}, 32'h1);
    step(0, 1, 0, 2'd2, 0, 32'h1000, 0, o);          chk("err_rng", {31'h0, err0}, 32'h1);
    step(0, 1, 0, 2'd2, 0, 32'h04, 0, o);            chk("unchg4", o, 32'h00000013);
    step(0, 1, 1, 2'd1, 0, 32'h12, 32'h0000ABCD, o);
    step(0, 1, 0, 2'd1, 0, 32'h12, 0, o);            chk("raw_h", o, 32'hFFFFABCD);

    // Randomized traffic
    for (int i = 0; i < 400; i++) rnd_step($urandom_range(0, 9) < 8);

    // Reset at sweep count 7 after a store to word 0
    step(0, 1, 1, 2'd2, 0, 32'h0, 32'h00001234, o);
    step(0, 1, 0, 2'd2, 0, 32'h0, 0, o);             chk("ld_1234", o, 32'h00001234);
    step(1, 0, 0, 2'd2, 0, 32'h0, 0, o);
    for (int i = 0; i < 7; i++) rnd_step(1'b1);
    step(1, 0, 0, 2'd2, 0, 32'h0, 0, o);
    for (int i = 0; i < DEPTH; i++) rnd_step(1'b1);
    step(0, 1, 0, 2'd2, 0, 32'h0, 0, o);             chk("ld_after_rst", o, 32'h00000013);

    for (int i = 0; i < 200; i++) rnd_step($urandom_range(0, 9) < 8);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 2'd2, 0, 32'h0, 0, o);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
